mcdt_arbiter: RTL and testbench
===============================

# mcdt_arbiter

Output arbiter and sequencer of the multi-channel data transfer (MCDT) block. It sits between the three per-channel slave FIFOs and the single MCDT output port. It selects one non-empty channel using per-channel static priority with round-robin tie-break, then pops up to a configured burst of words from that channel. Popped words are presented on mcdt_data_o / mcdt_val_o / mcdt_id_o with one cycle of latency.

## Interface
Parameters:
- DW, 32, data width of every channel and of the output.
- BURST_MAX, 4, largest burst length accepted on cfg_burst_i.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-high.
- slvN_data_i (N=0..2)  in  DW  FIFO head word, show-ahead; valid whenever slvN_val_i=1.
- slvN_val_i (N=0..2)  in  1  FIFO N non-empty.
- slvN_pop_o (N=0..2)  out  1  pop FIFO N this cycle; combinational.
- slvN_prio_i (N=0..2)  in  2  static priority; 0 is highest, 3 is lowest.
- cfg_burst_i  in  3  words per grant; 0 means 1; values above BURST_MAX clamp to BURST_MAX.
- arb_en_i  in  1  allow new grants.
- mcdt_data_o  out  DW  output word; registered.
- mcdt_val_o  out  1  output word valid; registered.
- mcdt_id_o  out  2  source channel of the output word; registered.
- busy_o  out  1  state is BURST.

## Operation
- FSM states: IDLE and BURST. Internal registers: owner (2b), cnt (3b), last_id (2b).
- IDLE, when arb_en_i=1 and any slvN_val_i=1:
  - Winner is the valid channel with the lowest prio value.
  - Ties are searched round-robin, starting from last_id+1 mod 3.
  - Pop the winner this cycle. Set owner=winner, last_id=winner, cnt=eff_burst-1.
  - If cnt≠0, go to BURST; otherwise stay in IDLE and re-arbitrate next cycle.
- IDLE, when arb_en_i=0 or no channel valid: no pop; stay in IDLE.
- BURST:
  - If slv[owner]_val_i=1: pop owner and decrement cnt. When cnt reaches 0, go to IDLE.
  - If slv[owner]_val_i=0: the burst ends early; no pop; go to IDLE.
  - Only the owner is popped; no re-arbitration inside a burst.
  - Priority or cfg_burst_i changes mid-burst take effect at the next grant.
- arb_en_i deasserted during BURST: the current burst completes; it only blocks new grants from IDLE.
- At most one slvN_pop_o is high in any cycle. A pop is issued only when the target's val=1.
- Output register, every cycle:
  - mcdt_val_o <= any pop.
  - mcdt_data_o <= popped word if a pop occurred, else 0.
  - mcdt_id_o <= popped channel if a pop occurred; otherwise it holds its value.
- eff_burst is derived from cfg_burst_i: 0 maps to 1; values above BURST_MAX map to BURST_MAX.

## Timing
- Reset values: state=IDLE, cnt=0, owner=0, last_id=2 (so ch0 wins the first tie), mcdt_data_o=0, mcdt_val_o=0, mcdt_id_o=0, busy_o=0.
- While rstn=1, all slvN_pop_o are forced to 0.
- Latency: a pop in cycle T appears on the mcdt_* outputs after edge T+1.
- Throughput: one word per cycle, including across grant boundaries (IDLE→IDLE and BURST→IDLE→grant). The only bubble is the IDLE cycle that follows an early-terminated burst.
- Reset asserted mid-burst: the burst is aborted, outputs clear asynchronously, and no further pops occur. After release, arbitration restarts from IDLE with last_id=2.
- Simultaneous requests of equal priority: strict rotation ch0→ch1→ch2→ch0 per grant.
- A higher-priority channel that starves lower ones is permitted by design. There is no aging.

## Structure
- Package mcdt_pkg holds:
  - the CH_NUM=3 constant;
  - typedef ch_id_t (logic [1:0]);
  - typedef prio_t (logic [1:0]);
  - enum arb_state_t {IDLE, BURST}.
- One combinational sub-module, mcdt_rr_pick. Inputs: val[2:0], prio[3][2], last_id. Outputs: any, winner. It is instantiated once and is reusable by other schedulers.

## Test plan
- Single channel: cfg_burst=4; ch0 holds 100 words, 0x00C00000+i; ch1/ch2 empty. Required: mcdt_val_o high for 100 consecutive cycles; data increments 0x00C00000..0x00C00063; id=0; busy_o toggles once per 4 words.
- Equal priority round-robin: all prio=0, burst=2, every FIFO always non-empty. Required: id sequence 0,0,1,1,2,2,0,0…; no idle cycles.
- Strict priority: prio ch0=3, ch1=3, ch2=0; all non-empty; burst=1. Required: only id=2 output until ch2 empties, then ch0 and ch1 alternate starting with ch0.
- Early termination: ch1 owns a burst of 4 and empties after 2 words; ch0 valid. Required: 2 words with id=1, one idle output cycle, then id=0 words.
- Config edges:
  - burst=0 behaves as 1.
  - burst=7 behaves as 4.
  - arb_en_i dropped mid-burst: the burst finishes, then no pops until re-enabled.
- Reset mid-burst: assert rstn after the 2nd word of a burst of 4. Required: pops drop immediately; outputs clear to 0; after release the first tie grant goes to ch0.

Source files
------------

// File: rtl/mcdt_pkg.sv
// Shared types and constants for the MCDT output arbiter and its schedulers.
// ch_wrap folds a 0..4 channel sum back into the 0..2 range.
package mcdt_pkg;

  localparam int CH_NUM = 3;

  typedef logic [1:0] ch_id_t;
  typedef logic [1:0] prio_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic ch_id_t ch_wrap(input logic [2:0] v);
    return (v >= 3'(CH_NUM)) ? ch_id_t'(v - 3'(CH_NUM)) : ch_id_t'(v);
  endfunction

endpackage

// File: rtl/mcdt_rr_pick.sv
// Picks the valid channel with the lowest priority value.
// Ties are searched round-robin, starting at the channel after last_id_i.
module mcdt_rr_pick
  import mcdt_pkg::*;
(
  input  logic [CH_NUM-1:0] val_i,
  input  prio_t             prio_i [CH_NUM],
  input  ch_id_t            last_id_i,
  output logic              any_o,
  output ch_id_t            winner_o
);

  prio_t  best_prio;
  ch_id_t start;
  ch_id_t idx;
  logic   found;

  assign any_o = |val_i;

  always_comb begin
    best_prio = 2'd3;
    for (int i = 0; i < CH_NUM; i++) begin
      if (val_i[i] && (prio_i[i] < best_prio)) best_prio = prio_i[i];
    end

    start    = ch_wrap({1'b0, last_id_i} + 3'd1);
    idx      = '0;
    winner_o = '0;
    found    = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = ch_wrap({1'b0, start} + 3'(k));
      if (!found && val_i[idx] && (prio_i[idx] == best_prio)) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcdt_arbiter.sv
// MCDT output arbiter: grants one slave FIFO at a time and pops up to a
// configured burst from it; popped words appear on mcdt_* one cycle later.
module mcdt_arbiter
  import mcdt_pkg::*;
#(
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] slv0_data_i,
  input  logic          slv0_val_i,
  output logic          slv0_pop_o,
  input  logic [1:0]    slv0_prio_i,
  input  logic [DW-1:0] slv1_data_i,
  input  logic          slv1_val_i,
  output logic          slv1_pop_o,
  input  logic [1:0]    slv1_prio_i,
  input  logic [DW-1:0] slv2_data_i,
  input  logic          slv2_val_i,
  output logic          slv2_pop_o,
  input  logic [1:0]    slv2_prio_i,
  input  logic [2:0]    cfg_burst_i,
  input  logic          arb_en_i,
  output logic [DW-1:0] mcdt_data_o,
  output logic          mcdt_val_o,
  output logic [1:0]    mcdt_id_o,
  output logic          busy_o
);

  logic [CH_NUM-1:0] val_vec;
  logic [CH_NUM-1:0] pop_vec;
  logic [DW-1:0]     data_arr [CH_NUM];
  prio_t             prio_arr [CH_NUM];

  arb_state_t state_q, state_d;
  ch_id_t     owner_q, owner_d;
  ch_id_t     last_id_q, last_id_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] eff_burst;

  logic   pick_any;
  ch_id_t pick_winner;
  logic   grant;
  logic   pop_any;
  ch_id_t pop_id;

  assign val_vec     = {slv2_val_i, slv1_val_i, slv0_val_i};
  assign data_arr[0] = slv0_data_i;
  assign data_arr[1] = slv1_data_i;
  assign data_arr[2] = slv2_data_i;
  assign prio_arr[0] = slv0_prio_i;
  assign prio_arr[1] = slv1_prio_i;
  assign prio_arr[2] = slv2_prio_i;

  mcdt_rr_pick u_pick (
    .val_i     (val_vec),
    .prio_i    (prio_arr),
    .last_id_i (last_id_q),
    .any_o     (pick_any),
    .winner_o  (pick_winner)
  );

  always_comb begin
    if (cfg_burst_i == 3'd0)                 eff_burst = 3'd1;
    else if (cfg_burst_i > 3'(BURST_MAX))    eff_burst = 3'(BURST_MAX);
    else                                     eff_burst = cfg_burst_i;
  end

  assign grant = (state_q == IDLE) && arb_en_i && pick_any;

  // State register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_id_q <= 2'd2;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic; cnt holds the words still owed after the current pop
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_id_d = last_id_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d   = pick_winner;
          last_id_d = pick_winner;
          cnt_d     = eff_burst - 3'd1;
          state_d   = (eff_burst == 3'd1) ? IDLE : BURST;
        end
      end
      BURST: begin
        if (val_vec[owner_q]) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: pops are combinational and suppressed while reset is held
  always_comb begin
    pop_vec = '0;
    pop_any = 1'b0;
    pop_id  = owner_q;
    if (!rstn) begin
      if (grant) begin
        pop_any = 1'b1;
        pop_id  = pick_winner;
      end else if ((state_q == BURST) && val_vec[owner_q]) begin
        pop_any = 1'b1;
      end
      if (pop_any) pop_vec[pop_id] = 1'b1;
    end
  end

  assign slv0_pop_o = pop_vec[0];
  assign slv1_pop_o = pop_vec[1];
  assign slv2_pop_o = pop_vec[2];
  assign busy_o     = (state_q == BURST);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      mcdt_data_o <= '0;
      mcdt_val_o  <= 1'b0;
      mcdt_id_o   <= '0;
    end else begin
      mcdt_val_o  <= pop_any;
      mcdt_data_o <= pop_any ? data_arr[pop_id] : '0;
      if (pop_any) mcdt_id_o <= pop_id;
    end
  end

endmodule

// File: tb/tb_mcdt_arbiter.sv
// Directed bench for mcdt_arbiter: FIFO models feed the slaves, every output
// cycle is logged and compared against hand-derived sequences.
module tb_mcdt_arbiter;
  import mcdt_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [DW-1:0] slv0_data_i, slv1_data_i, slv2_data_i;
  logic          slv0_val_i, slv1_val_i, slv2_val_i;
  logic          slv0_pop_o, slv1_pop_o, slv2_pop_o;
  logic [1:0]    slv0_prio_i, slv1_prio_i, slv2_prio_i;
  logic [2:0]    cfg_burst_i;
  logic          arb_en_i;
  logic [DW-1:0] mcdt_data_o;
  logic          mcdt_val_o;
  logic [1:0]    mcdt_id_o;
  logic          busy_o;

  mcdt_arbiter #(.DW(DW), .BURST_MAX(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .slv0_data_i (slv0_data_i),
    .slv0_val_i  (slv0_val_i),
    .slv0_pop_o  (slv0_pop_o),
    .slv0_prio_i (slv0_prio_i),
    .slv1_data_i (slv1_data_i),
    .slv1_val_i  (slv1_val_i),
    .slv1_pop_o  (slv1_pop_o),
    .slv1_prio_i (slv1_prio_i),
    .slv2_data_i (slv2_data_i),
    .slv2_val_i  (slv2_val_i),
    .slv2_pop_o  (slv2_pop_o),
    .slv2_prio_i (slv2_prio_i),
    .cfg_burst_i (cfg_burst_i),
    .arb_en_i    (arb_en_i),
    .mcdt_data_o (mcdt_data_o),
    .mcdt_val_o  (mcdt_val_o),
    .mcdt_id_o   (mcdt_id_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq0 [$];
  logic [DW-1:0] fq1 [$];
  logic [DW-1:0] fq2 [$];
  logic [DW-1:0] log_data [$];
  logic          log_val  [$];
  logic [1:0]    log_id   [$];
  logic          log_busy [$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic refresh();
    slv0_val_i  = (fq0.size() != 0);
    slv1_val_i  = (fq1.size() != 0);
    slv2_val_i  = (fq2.size() != 0);
    slv0_data_i = slv0_val_i ? fq0[0] : '0;
    slv1_data_i = slv1_val_i ? fq1[0] : '0;
    slv2_data_i = slv2_val_i ? fq2[0] : '0;
  endtask

  task automatic load(input int ch, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      case (ch)
        0:       fq0.push_back(base + DW'(i));
        1:       fq1.push_back(base + DW'(i));
        default: fq2.push_back(base + DW'(i));
      endcase
    end
    refresh();
  endtask

  task automatic clear_all();
    fq0.delete(); fq1.delete(); fq2.delete();
    log_data.delete(); log_val.delete(); log_id.delete(); log_busy.delete();
    refresh();
  endtask

  // One clock: check pop legality mid-cycle, then retire pops and log outputs.
  task automatic tick();
    logic [2:0] pc, vv;
    @(negedge clk);
    pc = {slv2_pop_o, slv1_pop_o, slv0_pop_o};
    vv = {slv2_val_i, slv1_val_i, slv0_val_i};
    check("pop_onehot", 64'($countones(pc) <= 1), 64'd1);
    check("pop_needs_val", 64'(pc & ~vv), 64'd0);
    if (rstn) check("pop_in_reset", 64'(pc), 64'd0);
    @(posedge clk);
    #1;
    if (pc[0]) void'(fq0.pop_front());
    if (pc[1]) void'(fq1.pop_front());
    if (pc[2]) void'(fq2.pop_front());
    refresh();
    log_val.push_back(mcdt_val_o);
    log_data.push_back(mcdt_data_o);
    log_id.push_back(mcdt_id_o);
    log_busy.push_back(busy_o);
    if (mcdt_val_o)
      $display("[%0t] word id=%0d data=%08h busy=%b", $time, mcdt_id_o, mcdt_data_o, busy_o);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    clear_all();
    run(2);
    rstn = 1'b0;
    log_data.delete(); log_val.delete(); log_id.delete(); log_busy.delete();
  endtask

  task automatic set_prio(input logic [1:0] p0, input logic [1:0] p1, input logic [1:0] p2);
    slv0_prio_i = p0; slv1_prio_i = p1; slv2_prio_i = p2;
  endtask

  initial begin
    logic [DW-1:0] base [3];
    int ch, idx;
    logic [1:0] exp_ids [$];
    base[0] = 32'hA000_0000; base[1] = 32'hB000_0000; base[2] = 32'hC000_0000;

    // Reset state, with ch0 already non-empty
    set_prio(2'd0, 2'd0, 2'd0);
    cfg_burst_i = 3'd4;
    arb_en_i    = 1'b1;
    clear_all();
    load(0, 32'h00C0_0000, 100);
    run(2);
    check("rst_val", 64'(mcdt_val_o), 64'd0);
    check("rst_data", 64'(mcdt_data_o), 64'd0);
    check("rst_id", 64'(mcdt_id_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);

    // Single channel, burst 4, 100 words back-to-back
    rstn = 1'b0;
    log_data.delete(); log_val.delete(); log_id.delete(); log_busy.delete();
    run(102);
    for (int i = 0; i < 100; i++) begin
      check("single_val", 64'(log_val[i]), 64'd1);
      check("single_data", 64'(log_data[i]), 64'(32'h00C0_0000 + i));
      check("single_id", 64'(log_id[i]), 64'd0);
      check("single_busy", 64'(log_busy[i]), 64'((i % 4) != 3));
    end
    check("single_tail", 64'(log_val[100]), 64'd0);

    // Equal priority round-robin, burst 2
    do_reset();
    cfg_burst_i = 3'd2;
    for (int c = 0; c < 3; c++) load(c, base[c], 20);
    run(12);
    for (int i = 0; i < 12; i++) begin
      ch  = (i / 2) % 3;
      idx = (i / 6) * 2 + (i % 2);
      check("rr_val", 64'(log_val[i]), 64'd1);
      check("rr_id", 64'(log_id[i]), 64'(ch));
      check("rr_data", 64'(log_data[i]), 64'(base[ch] + DW'(idx)));
    end

    // Strict priority: ch2 drains first, then ch0/ch1 alternate from ch0
    do_reset();
    cfg_burst_i = 3'd1;
    set_prio(2'd3, 2'd3, 2'd0);
    load(0, base[0], 4); load(1, base[1], 4); load(2, base[2], 3);
    run(12);
    exp_ids = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    for (int i = 0; i < 11; i++) begin
      check("prio_val", 64'(log_val[i]), 64'd1);
      check("prio_id", 64'(log_id[i]), 64'(exp_ids[i]));
    end
    check("prio_data2", 64'(log_data[2]), 64'(base[2] + 2));
    check("prio_data3", 64'(log_data[3]), 64'(base[0]));
    check("prio_tail", 64'(log_val[11]), 64'd0);

    // Early termination: ch1 owns a burst of 4 but holds only 2 words
    do_reset();
    cfg_burst_i = 3'd4;
    set_prio(2'd1, 2'd0, 2'd0);
    load(0, base[0], 3); load(1, base[1], 2);
    run(7);
    check("early_v0", 64'(log_val[0]), 64'd1);
    check("early_id0", 64'(log_id[0]), 64'd1);
    check("early_d1", 64'(log_data[1]), 64'(base[1] + 1));
    check("early_bubble_val", 64'(log_val[2]), 64'd0);
    check("early_bubble_data", 64'(log_data[2]), 64'd0);
    check("early_bubble_id", 64'(log_id[2]), 64'd1);
    for (int i = 3; i < 6; i++) begin
      check("early_ch0_val", 64'(log_val[i]), 64'd1);
      check("early_ch0_id", 64'(log_id[i]), 64'd0);
      check("early_ch0_data", 64'(log_data[i]), 64'(base[0] + DW'(i - 3)));
    end
    check("early_tail", 64'(log_val[6]), 64'd0);

    // burst=0 behaves as 1
    do_reset();
    cfg_burst_i = 3'd0;
    set_prio(2'd0, 2'd0, 2'd0);
    load(0, base[0], 3); load(1, base[1], 3);
    run(6);
    for (int i = 0; i < 6; i++) begin
      check("b0_id", 64'(log_id[i]), 64'(i % 2));
      check("b0_busy", 64'(log_busy[i]), 64'd0);
    end

    // burst=7 clamps to 4
    do_reset();
    cfg_burst_i = 3'd7;
    load(0, base[0], 6); load(1, base[1], 6);
    run(9);
    for (int i = 0; i < 9; i++)
      check("b7_id", 64'(log_id[i]), 64'((i / 4) % 2));

    // arb_en dropped mid-burst: burst completes, then no grants
    do_reset();
    cfg_burst_i = 3'd4;
    load(0, base[0], 10); load(1, base[1], 10);
    run(1);
    arb_en_i = 1'b0;
    run(7);
    arb_en_i = 1'b1;
    run(1);
    for (int i = 0; i < 4; i++)
      check("en_burst_data", 64'(log_data[i]), 64'(base[0] + DW'(i)));
    for (int i = 4; i < 8; i++)
      check("en_off_val", 64'(log_val[i]), 64'd0);
    check("en_resume_id", 64'(log_id[8]), 64'd1);
    check("en_resume_data", 64'(log_data[8]), 64'(base[1]));

    // Reset asserted after the 2nd word of a burst of 4
    do_reset();
    load(0, base[0], 10); load(1, base[1], 10);
    run(2);
    check("mid_pre_data", 64'(log_data[1]), 64'(base[0] + 1));
    rstn = 1'b1;
    #1;
    check("mid_pops", 64'({slv2_pop_o, slv1_pop_o, slv0_pop_o}), 64'd0);
    check("mid_val", 64'(mcdt_val_o), 64'd0);
    check("mid_data", 64'(mcdt_data_o), 64'd0);
    check("mid_busy", 64'(busy_o), 64'd0);
    run(2);
    rstn = 1'b0;
    log_data.delete(); log_val.delete(); log_id.delete(); log_busy.delete();
    run(1);
    check("mid_after_id", 64'(log_id[0]), 64'd0);
    check("mid_after_data", 64'(log_data[0]), 64'(base[0] + 2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
